// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and constants for the OTTER program-counter unit:
//               next-PC source encoding, PC step and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

  // Next-PC source select. 6 and 7 both hold the PC.
  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_JALR   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JAL    = 3'd3,
    SEL_TRAP   = 3'd4,
    SEL_MRET   = 3'd5,
    SEL_HOLD6  = 3'd6,
    SEL_HOLD7  = 3'd7
  } pc_sel_t;

  localparam int PC_STEP       = 4;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_CNT_WIDTH = 64;

endpackage

`default_nettype wire

// File: rtl/pc_if.sv
// ============================================================================
// Module      : pc_if
// Description : Bundle between the fetch-stage control and the PC unit.
//               master : control side (drives write enable, select, targets)
//               slave  : pc_unit (drives PC_COUNT, PC_PLUS4, MEPC, INSTRET,
//                        MISALIGN)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_if
  import pc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();

  logic                 PC_WRITE;
  pc_sel_t              PC_SEL;
  logic [WIDTH-1:0]     JALR_TGT;
  logic [WIDTH-1:0]     BRANCH_TGT;
  logic [WIDTH-1:0]     JAL_TGT;
  logic [WIDTH-1:0]     MTVEC;
  logic [WIDTH-1:0]     PC_COUNT;
  logic [WIDTH-1:0]     PC_PLUS4;
  logic [WIDTH-1:0]     MEPC;
  logic [CNT_WIDTH-1:0] INSTRET;
  logic                 MISALIGN;

  modport master (
    output PC_WRITE, PC_SEL, JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC,
    input  PC_COUNT, PC_PLUS4, MEPC, INSTRET, MISALIGN
  );

  modport slave (
    input  PC_WRITE, PC_SEL, JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC,
    output PC_COUNT, PC_PLUS4, MEPC, INSTRET, MISALIGN
  );

endinterface

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module      : pc_unit
// Description : Program counter for the OTTER fetch stage. Selects the next
//               PC among sequential, jalr, branch, jal, trap vector and trap
//               return; keeps the exception PC (MEPC) and a retired
//               instruction counter.
// Ports       : CLK  - rising-edge clock
//               RST  - asynchronous active-high reset
//               bus  - pc_if.slave (PC_WRITE, PC_SEL, targets, MTVEC in;
//                      PC_COUNT, PC_PLUS4, MEPC, INSTRET, MISALIGN out)
// Options     : `define PC_MISALIGN_TRAP_EN to trap misaligned jalr/branch/jal
//               targets to MTVEC; otherwise MISALIGN is tied 0 and targets
//               load verbatim.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  wire  CLK,
  input  wire  RST,
  pc_if.slave  bus
);

  logic [WIDTH-1:0]     r_pc;
  logic [WIDTH-1:0]     r_mepc;
  logic [CNT_WIDTH-1:0] r_instret;

  logic [WIDTH-1:0]     w_pc_plus4;
  logic [WIDTH-1:0]     w_jalr_tgt;
  logic [WIDTH-1:0]     w_vec;
  logic [WIDTH-1:0]     w_next_pc;
  logic                 w_save_mepc;
  logic                 w_retire;
  logic                 w_misalign;

  assign w_pc_plus4 = r_pc + WIDTH'(PC_STEP);
  assign w_jalr_tgt = {bus.JALR_TGT[WIDTH-1:1], 1'b0};
  assign w_vec      = {bus.MTVEC[WIDTH-1:2], 2'b00};

  always_comb begin
    w_next_pc   = r_pc;
    w_save_mepc = 1'b0;
    w_retire    = 1'b0;
    case (bus.PC_SEL)
      SEL_SEQ:    begin w_next_pc = w_pc_plus4;     w_retire = 1'b1; end
      SEL_JALR:   begin w_next_pc = w_jalr_tgt;     w_retire = 1'b1; end
      SEL_BRANCH: begin w_next_pc = bus.BRANCH_TGT; w_retire = 1'b1; end
      SEL_JAL:    begin w_next_pc = bus.JAL_TGT;    w_retire = 1'b1; end
      SEL_TRAP:   begin w_next_pc = w_vec;          w_save_mepc = 1'b1; end
      SEL_MRET:   begin w_next_pc = r_mepc;         w_retire = 1'b1; end
      default:    w_next_pc = r_pc;
    endcase

`ifdef PC_MISALIGN_TRAP_EN
    // A redirect whose resolved target is not word aligned becomes a trap:
    // vector taken, current PC saved, instruction not retired.
    w_misalign = 1'b0;
    if ((bus.PC_SEL == SEL_JALR || bus.PC_SEL == SEL_BRANCH ||
         bus.PC_SEL == SEL_JAL) && (w_next_pc[1:0] != 2'b00)) begin
      w_misalign  = 1'b1;
      w_next_pc   = w_vec;
      w_save_mepc = 1'b1;
      w_retire    = 1'b0;
    end
`else
    w_misalign = 1'b0;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc      <= RESET_VEC;
      r_mepc    <= '0;
      r_instret <= '0;
    end else if (bus.PC_WRITE) begin
      r_pc <= w_next_pc;
      if (w_save_mepc) r_mepc    <= r_pc;
      if (w_retire)    r_instret <= r_instret + CNT_WIDTH'(1);
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_misalign <= 1'b0;
    else     r_misalign <= bus.PC_WRITE & w_misalign;
  end

  assign bus.MISALIGN = r_misalign;
`else
  // Only referenced by the alignment check when that option is built.
  logic w_unused_bits;
  assign w_unused_bits = w_misalign;
  assign bus.MISALIGN  = 1'b0;
`endif

  assign bus.PC_COUNT = r_pc;
  assign bus.PC_PLUS4 = w_pc_plus4;
  assign bus.MEPC     = r_mepc;
  assign bus.INSTRET  = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none

module tb_pc_unit;
  import pc_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pc_if #(.WIDTH(32), .CNT_WIDTH(64)) bus ();
  pc_if #(.WIDTH(32), .CNT_WIDTH(8))  bus8 ();

  pc_unit #(.WIDTH(32), .RESET_VEC(32'h100), .CNT_WIDTH(64)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  pc_unit #(.WIDTH(32), .RESET_VEC(32'h100), .CNT_WIDTH(8)) u_dut8 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus8)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_cnt;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input pc_sel_t s);
    bus.PC_SEL   = s;
    bus.PC_WRITE = 1'b1;
    tick();
    bus.PC_WRITE = 1'b0;
  endtask

  task automatic test_reset();
    bus.PC_WRITE = 1'b0;
    bus.PC_SEL = SEL_SEQ;
    bus.JALR_TGT = '0; bus.BRANCH_TGT = '0; bus.JAL_TGT = '0; bus.MTVEC = '0;
    bus8.PC_WRITE = 1'b0; bus8.PC_SEL = SEL_SEQ;
    bus8.JALR_TGT = '0; bus8.BRANCH_TGT = '0; bus8.JAL_TGT = '0; bus8.MTVEC = '0;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    vectors++;
    if (bus.PC_COUNT !== 32'h100) begin miscompares++;
      $display("FAIL reset_init pc got %h exp %h", bus.PC_COUNT, 32'h100); end
    // Make state non-trivial, then reset mid-cycle without a clock edge.
    bus.JAL_TGT = 32'h500; wr(SEL_JAL);
    bus.MTVEC = 32'h0;     wr(SEL_TRAP);
    vectors++;
    if (bus.MEPC !== 32'h500) begin miscompares++;
      $display("FAIL pre_reset_mepc got %h exp %h", bus.MEPC, 32'h500); end
    #2 RST = 1'b1;
    #1;
    vectors++;
    if (bus.PC_COUNT !== 32'h100) begin miscompares++;
      $display("FAIL async_reset_pc got %h exp %h", bus.PC_COUNT, 32'h100); end
    vectors++;
    if (bus.MEPC !== 32'h0) begin miscompares++;
      $display("FAIL async_reset_mepc got %h exp %h", bus.MEPC, 32'h0); end
    vectors++;
    if (bus.INSTRET !== 64'h0) begin miscompares++;
      $display("FAIL async_reset_instret got %h exp %h", bus.INSTRET, 64'h0); end
    vectors++;
    if (bus.MISALIGN !== 1'b0) begin miscompares++;
      $display("FAIL async_reset_misalign got %b exp 0", bus.MISALIGN); end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    exp_cnt = 64'd0;
    wr(SEL_SEQ); wr(SEL_SEQ); wr(SEL_SEQ);
    exp_cnt = 64'd3;
    vectors++;
    if (bus.PC_COUNT !== 32'h10C) begin miscompares++;
      $display("FAIL seq3_pc got %h exp %h", bus.PC_COUNT, 32'h10C); end
    vectors++;
    if (bus.INSTRET !== exp_cnt) begin miscompares++;
      $display("FAIL seq3_instret got %0d exp %0d", bus.INSTRET, exp_cnt); end
    vectors++;
    if (bus.PC_PLUS4 !== 32'h110) begin miscompares++;
      $display("FAIL seq3_plus4 got %h exp %h", bus.PC_PLUS4, 32'h110); end
  endtask

  task automatic test_redirect();
    bus.JAL_TGT = 32'h100; wr(SEL_JAL);
    bus.JAL_TGT = 32'h200; wr(SEL_JAL);
    vectors++;
    if (bus.PC_COUNT !== 32'h200) begin miscompares++;
      $display("FAIL jal_pc got %h exp %h", bus.PC_COUNT, 32'h200); end
    bus.JALR_TGT = 32'h301; wr(SEL_JALR);
    vectors++;
    if (bus.PC_COUNT !== 32'h300) begin miscompares++;
      $display("FAIL jalr_pc got %h exp %h", bus.PC_COUNT, 32'h300); end
    bus.BRANCH_TGT = 32'h80; wr(SEL_BRANCH);
    vectors++;
    if (bus.PC_COUNT !== 32'h80) begin miscompares++;
      $display("FAIL branch_pc got %h exp %h", bus.PC_COUNT, 32'h80); end
    exp_cnt = 64'd7;
    vectors++;
    if (bus.INSTRET !== exp_cnt) begin miscompares++;
      $display("FAIL redirect_instret got %0d exp %0d", bus.INSTRET, exp_cnt); end
  endtask

  task automatic test_trap();
    bus.MTVEC = 32'h1003; wr(SEL_TRAP);
    vectors++;
    if (bus.PC_COUNT !== 32'h1000) begin miscompares++;
      $display("FAIL trap_pc got %h exp %h", bus.PC_COUNT, 32'h1000); end
    vectors++;
    if (bus.MEPC !== 32'h80) begin miscompares++;
      $display("FAIL trap_mepc got %h exp %h", bus.MEPC, 32'h80); end
    vectors++;
    if (bus.INSTRET !== exp_cnt) begin miscompares++;
      $display("FAIL trap_instret got %0d exp %0d", bus.INSTRET, exp_cnt); end
    wr(SEL_MRET);
    exp_cnt = 64'd8;
    vectors++;
    if (bus.PC_COUNT !== 32'h80) begin miscompares++;
      $display("FAIL mret_pc got %h exp %h", bus.PC_COUNT, 32'h80); end
    vectors++;
    if (bus.MEPC !== 32'h80) begin miscompares++;
      $display("FAIL mret_mepc got %h exp %h", bus.MEPC, 32'h80); end
    vectors++;
    if (bus.INSTRET !== exp_cnt) begin miscompares++;
      $display("FAIL mret_instret got %0d exp %0d", bus.INSTRET, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    wr(SEL_TRAP);
    wr(SEL_TRAP);
    vectors++;
    if (bus.MEPC !== 32'h1000) begin miscompares++;
      $display("FAIL trap2_mepc got %h exp %h", bus.MEPC, 32'h1000); end
    vectors++;
    if (bus.PC_COUNT !== 32'h1000) begin miscompares++;
      $display("FAIL trap2_pc got %h exp %h", bus.PC_COUNT, 32'h1000); end
    wr(SEL_MRET);
    exp_cnt = 64'd9;
    vectors++;
    if (bus.PC_COUNT !== 32'h1000) begin miscompares++;
      $display("FAIL trap2_mret_pc got %h exp %h", bus.PC_COUNT, 32'h1000); end
    vectors++;
    if (bus.INSTRET !== exp_cnt) begin miscompares++;
      $display("FAIL trap2_instret got %0d exp %0d", bus.INSTRET, exp_cnt); end
  endtask

  task automatic test_stall();
    bus.PC_SEL = SEL_JAL;
    bus.JAL_TGT = 32'h444;
    bus.PC_WRITE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (bus.PC_COUNT !== 32'h1000 || bus.MEPC !== 32'h1000 ||
          bus.INSTRET !== exp_cnt || bus.PC_PLUS4 !== 32'h1004) begin
        miscompares++;
        $display("FAIL stall_hold cyc %0d got pc=%h mepc=%h cnt=%0d p4=%h exp pc=1000 mepc=1000 cnt=%0d p4=1004",
                 i, bus.PC_COUNT, bus.MEPC, bus.INSTRET, bus.PC_PLUS4, exp_cnt);
      end
    end
    wr(SEL_HOLD7);
    vectors++;
    if (bus.PC_COUNT !== 32'h1000 || bus.INSTRET !== exp_cnt) begin miscompares++;
      $display("FAIL hold7 got pc=%h cnt=%0d exp pc=1000 cnt=%0d", bus.PC_COUNT, bus.INSTRET, exp_cnt); end
    wr(SEL_HOLD6);
    vectors++;
    if (bus.PC_COUNT !== 32'h1000 || bus.INSTRET !== exp_cnt) begin miscompares++;
      $display("FAIL hold6 got pc=%h cnt=%0d exp pc=1000 cnt=%0d", bus.PC_COUNT, bus.INSTRET, exp_cnt); end
  endtask

  task automatic test_wrap();
    bus.JAL_TGT = 32'hFFFF_FFFC; wr(SEL_JAL);
    vectors++;
    if (bus.PC_PLUS4 !== 32'h0) begin miscompares++;
      $display("FAIL wrap_plus4 got %h exp %h", bus.PC_PLUS4, 32'h0); end
    wr(SEL_SEQ);
    exp_cnt = 64'd11;
    vectors++;
    if (bus.PC_COUNT !== 32'h0) begin miscompares++;
      $display("FAIL wrap_pc got %h exp %h", bus.PC_COUNT, 32'h0); end
    vectors++;
    if (bus.INSTRET !== exp_cnt) begin miscompares++;
      $display("FAIL wrap_instret64 got %0d exp %0d", bus.INSTRET, exp_cnt); end
    // 8-bit counter instance: 255 retirements, then one more wraps to 0.
    bus8.PC_SEL = SEL_SEQ;
    bus8.PC_WRITE = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    bus8.PC_WRITE = 1'b0;
    vectors++;
    if (bus8.INSTRET !== 8'd255) begin miscompares++;
      $display("FAIL cnt8_full got %0d exp 255", bus8.INSTRET); end
    bus8.PC_WRITE = 1'b1;
    tick();
    bus8.PC_WRITE = 1'b0;
    vectors++;
    if (bus8.INSTRET !== 8'd0) begin miscompares++;
      $display("FAIL cnt8_wrap got %0d exp 0", bus8.INSTRET); end
  endtask

  task automatic test_misalign();
    bus.JAL_TGT = 32'h40; wr(SEL_JAL);
    exp_cnt = 64'd12;
    bus.MTVEC = 32'h800;
    bus.BRANCH_TGT = 32'h102;
    wr(SEL_BRANCH);
`ifdef PC_MISALIGN_TRAP_EN
    vectors++;
    if (bus.PC_COUNT !== 32'h800) begin miscompares++;
      $display("FAIL mis_pc got %h exp %h", bus.PC_COUNT, 32'h800); end
    vectors++;
    if (bus.MEPC !== 32'h40) begin miscompares++;
      $display("FAIL mis_mepc got %h exp %h", bus.MEPC, 32'h40); end
    vectors++;
    if (bus.MISALIGN !== 1'b1) begin miscompares++;
      $display("FAIL mis_pulse got %b exp 1", bus.MISALIGN); end
`else
    exp_cnt = 64'd13;
    vectors++;
    if (bus.PC_COUNT !== 32'h102) begin miscompares++;
      $display("FAIL mis_off_pc got %h exp %h", bus.PC_COUNT, 32'h102); end
    vectors++;
    if (bus.MISALIGN !== 1'b0) begin miscompares++;
      $display("FAIL mis_off_pulse got %b exp 0", bus.MISALIGN); end
`endif
    vectors++;
    if (bus.INSTRET !== exp_cnt) begin miscompares++;
      $display("FAIL mis_instret got %0d exp %0d", bus.INSTRET, exp_cnt); end
    tick();
    vectors++;
    if (bus.MISALIGN !== 1'b0) begin miscompares++;
      $display("FAIL mis_clear got %b exp 0", bus.MISALIGN); end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_trap();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the OTTER fetch stage, replacing the plain load/reset PC register. It holds the current PC and selects the next PC among sequential, branch, jal, jalr, trap-vector and trap-return sources. It keeps its own exception PC (MEPC) and a retired-instruction counter. Outputs feed instruction memory, the immediate/target generator and the CSR file.

## Interface
- WIDTH, 32, PC and target width in bits (≥8)
- RESET_VEC, 0, PC value loaded by reset (WIDTH bits, 4-byte aligned)
- CNT_WIDTH, 64, width of retired-instruction counter
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- PC_WRITE  in  1  update enable; when 0, all registers hold
- PC_SEL  in  3  next-PC source (pc_sel_t): 0 SEQ, 1 JALR, 2 BRANCH, 3 JAL, 4 TRAP, 5 MRET, 6/7 HOLD
- JALR_TGT  in  WIDTH  jalr target (rs1+imm)
- BRANCH_TGT  in  WIDTH  branch target
- JAL_TGT  in  WIDTH  jal target
- MTVEC  in  WIDTH  trap vector base
- PC_COUNT  out  WIDTH  current PC, registered
- PC_PLUS4  out  WIDTH  PC_COUNT+4, combinational
- MEPC  out  WIDTH  saved exception PC, registered
- INSTRET  out  CNT_WIDTH  retired-instruction count, registered
- MISALIGN  out  1  one-cycle pulse: misaligned target trapped (macro only)

## Operation
- Reset values: PC_COUNT=RESET_VEC, MEPC=0, INSTRET=0, MISALIGN=0.
- With PC_WRITE=1, at the clock edge, PC_COUNT takes:
  - SEQ: PC_PLUS4
  - JALR: JALR_TGT with bit0 cleared (always)
  - BRANCH: BRANCH_TGT
  - JAL: JAL_TGT
  - TRAP: {MTVEC[WIDTH-1:2],2'b00}; MEPC<=PC_COUNT in the same edge
  - MRET: MEPC
  - HOLD (6/7): PC unchanged
- With PC_WRITE=0, PC_COUNT, MEPC and INSTRET hold; MISALIGN clears to 0.
- Arithmetic: PC_PLUS4 is modulo 2^WIDTH, so all-ones-minus-3 wraps to 0. Targets pass through unmodified except as stated above.
- INSTRET increments by 1 on each PC_WRITE edge with SEL in SEQ/JALR/BRANCH/JAL/MRET, unless that edge takes a misalign trap. TRAP and HOLD do not increment. The counter wraps modulo 2^CNT_WIDTH.
- MEPC changes only on TRAP or a misalign trap. MRET leaves MEPC unchanged.
- TRAP immediately after TRAP overwrites MEPC with the current PC, which is the vector address. No nesting.

## Timing
- Next PC appears on PC_COUNT 1 cycle after the PC_WRITE edge. PC_PLUS4 is valid in the same cycle as PC_COUNT.
- MEPC and INSTRET update on the same edge as PC_COUNT.
- MISALIGN is registered: high for exactly the cycle after the trapping edge.
- RST asserted at any time forces all reset values immediately, without waiting for CLK, and overrides PC_WRITE. On deassertion, the first edge with PC_WRITE=1 acts on RESET_VEC.
- No handshake. The control FSM owns PC_WRITE; the block assumes its inputs are stable at the edge.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - On a PC_WRITE edge with SEL ∈ {JALR, BRANCH, JAL} and the resolved target's bits[1:0] ≠ 0 (JALR checked after bit0 clear), the unit loads the aligned MTVEC instead.
  - MEPC<=PC_COUNT, MISALIGN pulses, INSTRET does not increment.
- Undefined:
  - MISALIGN is tied 0.
  - Misaligned targets load verbatim. No alignment check logic is synthesised.

## Structure
- Shared package pc_pkg:
  - pc_sel_t enum (3-bit, encodings above)
  - PC_STEP=4 constant
  - localparam defaults for WIDTH/CNT_WIDTH
- Flat module with no sub-module. Next-PC mux, alignment check and counter are inline.

## Test plan
- Reset: RST=1 mid-run, RESET_VEC=32'h100 → PC_COUNT=0x100, MEPC=0, INSTRET=0 without a clock edge. Then 3 SEQ writes → 0x10C, INSTRET=3.
- Redirects: from PC=0x100 apply JAL 0x200, JALR 0x301, BRANCH 0x80 in turn → PC sequence 0x200, 0x300, 0x80.
- Trap/return: PC=0x80, MTVEC=0x1003, TRAP → PC=0x1000, MEPC=0x80, INSTRET unchanged. MRET → PC=0x80.
- Stall and HOLD: PC_WRITE=0 for 5 cycles with SEL=JAL → all outputs hold. SEL=7 with PC_WRITE=1 → PC holds, INSTRET holds.
- Wrap: WIDTH=32, PC=0xFFFFFFFC, SEQ → PC=0. Force INSTRET to all-ones via CNT_WIDTH=8 build → 255+1 → 0.
- Macro on: BRANCH to 0x102 from PC=0x40, MTVEC=0x800 → PC=0x800, MEPC=0x40, MISALIGN high 1 cycle. Macro off: same stimulus → PC=0x102, MISALIGN=0.
